// File: rtl/decode_stage_if.sv
// decode_stage_if: bundle between fetch/writeBack/alu and the decode stage.
// master = the environment driving instructions and writebacks; slave = decode_stage.
interface decode_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stage2;
  logic [31:0]           curInstruction;
  logic                  wbRegWrite;
  logic [4:0]            wbRegAddr;
  logic [DATA_WIDTH-1:0] wbData;

  logic                  stage3;
  logic [5:0]            opcode;
  logic [4:0]            rs;
  logic [4:0]            rt;
  logic [4:0]            rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [31:0]           immediate;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  regDest;
  logic                  branch;
  logic                  memRead;
  logic                  memToReg;
  logic                  memWrite;
  logic                  aluSrc;
  logic                  regWrite;
  logic [1:0]            aluOP;
  logic                  endProgram;
  logic                  illegal;
  logic                  overrun;

  modport master (
    output stage2, curInstruction, wbRegWrite, wbRegAddr, wbData,
    input  stage3, opcode, rs, rt, rd, shamt, funct, immediate,
           readData1, readData2, regDest, branch, memRead, memToReg,
           memWrite, aluSrc, regWrite, aluOP, endProgram, illegal, overrun
  );

  modport slave (
    input  stage2, curInstruction, wbRegWrite, wbRegAddr, wbData,
    output stage3, opcode, rs, rt, rd, shamt, funct, immediate,
           readData1, readData2, regDest, branch, memRead, memToReg,
           memWrite, aluSrc, regWrite, aluOP, endProgram, illegal, overrun
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: stage 2 of the token-passed MIPS core. Latches the fetched
// instruction, splits fields, decodes controls, owns the 32-entry register
// file and hands operands to alu with a one-cycle stage3 token.
// Optional macro DECODE_BYPASS_EN: writeback in the READ cycle is forwarded
// straight into readData1/readData2 (write-through).
//
// state  | meaning
// IDLE   | waiting for a stage2 token
// DECODE | fields, immediate and controls registered from IR
// READ   | register-file operands registered
// ISSUE  | stage3 token asserted for this single cycle
// HALT   | halt opcode seen; terminal until start
module decode_stage #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input logic           clock,
  input logic           start,
  decode_stage_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DECODE, READ, ISSUE, HALT} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [31:0]           r_ir;
  logic [DATA_WIDTH-1:0] r_regs [32];

  logic [5:0]            r_opcode;
  logic [4:0]            r_rs, r_rt, r_rd, r_shamt;
  logic [5:0]            r_funct;
  logic [31:0]           r_imm;
  logic [DATA_WIDTH-1:0] r_rd1, r_rd2;
  logic [8:0]            r_ctrl;
  logic                  r_illegal, r_end, r_overrun;

  logic [8:0]            w_ctrl;
  logic                  w_illegal;
  logic                  w_is_halt;
  logic [DATA_WIDTH-1:0] w_rd1, w_rd2;

  assign w_is_halt = (r_ir[31:26] == HALT_OPCODE);

  // State register.
  always_ff @(posedge clock) begin
    if (start) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.stage2) w_state_next = DECODE;
      DECODE:  w_state_next = w_is_halt ? HALT : READ;
      READ:    w_state_next = ISSUE;
      ISSUE:   w_state_next = IDLE;
      HALT:    w_state_next = HALT;
      default: w_state_next = IDLE;
    endcase
  end

  // Control decode of the latched opcode:
  // {regDest, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOP}.
  always_comb begin
    w_ctrl    = '0;
    w_illegal = 1'b0;
    case (r_ir[31:26])
      6'b000000: w_ctrl = 9'b1000001_10;
      6'b100011: w_ctrl = 9'b0011011_00;
      6'b101011: w_ctrl = 9'b0000110_00;
      6'b000100: w_ctrl = 9'b0100000_01;
      6'b001000: w_ctrl = 9'b0000011_00;
      default:   w_illegal = !w_is_halt;
    endcase
  end

  // Operand read; register 0 always reads zero.
  always_comb begin
    w_rd1 = (r_rs == 5'd0) ? '0 : r_regs[r_rs];
    w_rd2 = (r_rt == 5'd0) ? '0 : r_regs[r_rt];
`ifdef DECODE_BYPASS_EN
    if (bus.wbRegWrite && (bus.wbRegAddr != 5'd0) && (bus.wbRegAddr == r_rs))
      w_rd1 = bus.wbData;
    if (bus.wbRegWrite && (bus.wbRegAddr != 5'd0) && (bus.wbRegAddr == r_rt))
      w_rd2 = bus.wbData;
`endif
  end

  // Register file: writeback accepted in every state, register 0 never written.
  always_ff @(posedge clock) begin
    if (start) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (bus.wbRegWrite && (bus.wbRegAddr != 5'd0)) begin
      r_regs[bus.wbRegAddr] <= bus.wbData;
    end
  end

  // IR capture, decoded outputs, operands and sticky flags.
  always_ff @(posedge clock) begin
    if (start) begin
      r_ir      <= '0;
      r_opcode  <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      r_shamt   <= '0;
      r_funct   <= '0;
      r_imm     <= '0;
      r_rd1     <= '0;
      r_rd2     <= '0;
      r_ctrl    <= '0;
      r_illegal <= 1'b0;
      r_end     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if ((r_state == IDLE) && bus.stage2) r_ir <= bus.curInstruction;
      if (r_state == DECODE) begin
        r_opcode  <= r_ir[31:26];
        r_rs      <= r_ir[25:21];
        r_rt      <= r_ir[20:16];
        r_rd      <= r_ir[15:11];
        r_shamt   <= r_ir[10:6];
        r_funct   <= r_ir[5:0];
        r_imm     <= {{16{r_ir[15]}}, r_ir[15:0]};
        r_ctrl    <= w_ctrl;
        r_illegal <= w_illegal;
        if (w_is_halt) r_end <= 1'b1;
      end
      if (r_state == READ) begin
        r_rd1 <= w_rd1;
        r_rd2 <= w_rd2;
      end
      // A token while busy is dropped; in HALT it is silently ignored.
      if (bus.stage2 && (r_state != IDLE) && (r_state != HALT)) r_overrun <= 1'b1;
    end
  end

  assign bus.stage3     = (r_state == ISSUE);
  assign bus.opcode     = r_opcode;
  assign bus.rs         = r_rs;
  assign bus.rt         = r_rt;
  assign bus.rd         = r_rd;
  assign bus.shamt      = r_shamt;
  assign bus.funct      = r_funct;
  assign bus.immediate  = r_imm;
  assign bus.readData1  = r_rd1;
  assign bus.readData2  = r_rd2;
  assign bus.regDest    = r_ctrl[8];
  assign bus.branch     = r_ctrl[7];
  assign bus.memRead    = r_ctrl[6];
  assign bus.memToReg   = r_ctrl[5];
  assign bus.memWrite   = r_ctrl[4];
  assign bus.aluSrc     = r_ctrl[3];
  assign bus.regWrite   = r_ctrl[2];
  assign bus.aluOP      = r_ctrl[1:0];
  assign bus.endProgram = r_end;
  assign bus.illegal    = r_illegal;
  assign bus.overrun    = r_overrun;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Each accepted instruction
// pushes its expected issue (cycle, fields, operands, controls) computed from a
// plain register array; a negedge monitor pops and compares on every stage3.
module tb_decode_stage;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic start = 1'b1;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] mregs [32];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  decode_stage_if #(.DATA_WIDTH(DW)) d_if();

  decode_stage #(.DATA_WIDTH(DW), .HALT_OPCODE(6'h3F)) dut (
    .clock(clock),
    .start(start),
    .bus  (d_if)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // {regDest, branch, memRead, memToReg, memWrite, aluSrc, regWrite, aluOP, illegal}
  function automatic logic [9:0] exp_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return 10'b1000001_10_0;
      6'b100011: return 10'b0011011_00_0;
      6'b101011: return 10'b0000110_00_0;
      6'b000100: return 10'b0100000_01_0;
      6'b001000: return 10'b0000011_00_0;
      6'b111111: return 10'b0000000_00_0;
      default:   return 10'b0000000_00_1;
    endcase
  endfunction

  function automatic void model_wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    if (en && (a != 5'd0)) mregs[a] = d;
  endfunction

  task automatic idle_inputs();
    d_if.stage2         = 1'b0;
    d_if.curInstruction = '0;
    d_if.wbRegWrite     = 1'b0;
    d_if.wbRegAddr      = '0;
    d_if.wbData         = '0;
  endtask

  task automatic do_reset();
    start = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    q.delete();
  endtask

  task automatic wb_cycle(input logic [4:0] a, input logic [31:0] d);
    d_if.wbRegWrite = 1'b1;
    d_if.wbRegAddr  = a;
    d_if.wbData     = d;
    model_wr(1'b1, a, d);
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  // Four-cycle transaction: token in cycle 0, writebacks planned per cycle.
  // Operands are those present after writes landing at the ends of cycles 0
  // and 1; the cycle-2 write is only visible in the bypass build.
  task automatic xact(input logic [31:0] instr, input logic [3:0] wen,
                      input logic [3:0][4:0] wa, input logic [3:0][31:0] wd,
                      input bit repulse);
    exp_t e;
    model_wr(wen[0], wa[0], wd[0]);
    model_wr(wen[1], wa[1], wd[1]);
    e.instr = instr;
    e.rd1   = mregs[instr[25:21]];
    e.rd2   = mregs[instr[20:16]];
`ifdef DECODE_BYPASS_EN
    if (wen[2] && (wa[2] != 5'd0) && (wa[2] == instr[25:21])) e.rd1 = wd[2];
    if (wen[2] && (wa[2] != 5'd0) && (wa[2] == instr[20:16])) e.rd2 = wd[2];
`endif
    model_wr(wen[2], wa[2], wd[2]);
    model_wr(wen[3], wa[3], wd[3]);
    e.cyc = cyc + 3;
    if (instr[31:26] != 6'h3F) q.push_back(e);
    for (int i = 0; i < 4; i++) begin
      d_if.stage2         = (i == 0) || (repulse && (i == 1));
      d_if.curInstruction = (i == 0) ? instr : ~instr;
      d_if.wbRegWrite     = wen[i];
      d_if.wbRegAddr      = wa[i];
      d_if.wbData         = wd[i];
      @(posedge clock);
      #1;
    end
    idle_inputs();
  endtask

  task automatic xs(input logic [31:0] instr);
    xact(instr, 4'b0000, '0, '0, 1'b0);
  endtask

  // Scoreboard monitor.
  always @(negedge clock) begin
    if (d_if.stage3) begin
      if (q.size() == 0) begin
        chk("unexpected_stage3", 64'(d_if.stage3), 64'd0);
      end else begin
        mon_e = q.pop_front();
        chk("stage3_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("fields", {32'd0, d_if.opcode, d_if.rs, d_if.rt, d_if.rd, d_if.shamt, d_if.funct},
            {32'd0, mon_e.instr});
        chk("immediate", 64'(d_if.immediate), 64'({{16{mon_e.instr[15]}}, mon_e.instr[15:0]}));
        chk("readData1", 64'(d_if.readData1), 64'(mon_e.rd1));
        chk("readData2", 64'(d_if.readData2), 64'(mon_e.rd2));
        chk("controls", 64'({d_if.regDest, d_if.branch, d_if.memRead, d_if.memToReg,
                             d_if.memWrite, d_if.aluSrc, d_if.regWrite, d_if.aluOP,
                             d_if.illegal}),
            64'(exp_ctrl(mon_e.instr[31:26])));
        chk("endProgram_issue", 64'(d_if.endProgram), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]       wen;
    logic [3:0][4:0]  wa;
    logic [3:0][31:0] wd;
    logic [5:0]       op;
    logic [31:0]      ins;
    int               k;

    idle_inputs();
    do_reset();

    chk("rst_stage3", 64'(d_if.stage3), 64'd0);
    chk("rst_fields", 64'({d_if.opcode, d_if.rs, d_if.rt, d_if.rd, d_if.shamt, d_if.funct}), 64'd0);
    chk("rst_immediate", 64'(d_if.immediate), 64'd0);
    chk("rst_readData", {d_if.readData1, d_if.readData2}, 64'd0);
    chk("rst_controls", 64'({d_if.regDest, d_if.branch, d_if.memRead, d_if.memToReg,
                             d_if.memWrite, d_if.aluSrc, d_if.regWrite, d_if.aluOP}), 64'd0);
    chk("rst_flags", 64'({d_if.endProgram, d_if.illegal, d_if.overrun}), 64'd0);

    // lw $3,4($2) with reg2 = 0x100
    wb_cycle(5'd2, 32'h100);
    xs(32'h8C430004);
    // add $6,$5,$5 with reg5 = 0xDEADBEEF
    wb_cycle(5'd5, 32'hDEADBEEF);
    xs(32'h00A53020);
    // write to reg 0 ignored; negative immediate
    wb_cycle(5'd0, 32'h1234);
    xs(32'h2001FFF0);
    // writeback to rs during READ
    wb_cycle(5'd5, 32'h11);
    wen = 4'b0100; wa = '0; wd = '0;
    wa[2] = 5'd5; wd[2] = 32'h77;
    xact(32'h8CA70000, wen, wa, wd, 1'b0);
    xs(32'h8CA70000);
    // illegal opcode still issues
    xs(32'h08000000);
    chk("illegal_sticky", 64'(d_if.illegal), 64'd1);
    xs(32'h10A50003);
    chk("illegal_cleared", 64'(d_if.illegal), 64'd0);
    chk("no_overrun_yet", 64'(d_if.overrun), 64'd0);

    // re-pulsed token while busy
    xact(32'hAC430008, 4'b0000, '0, '0, 1'b1);
    chk("overrun_set", 64'(d_if.overrun), 64'd1);

    // reset in the middle of READ
    do_reset();
    wb_cycle(5'd9, 32'hCAFE);
    d_if.stage2 = 1'b1;
    d_if.curInstruction = 32'h8D2A0000;
    @(posedge clock); #1;
    idle_inputs();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    chk("midrst_stage3", 64'(d_if.stage3), 64'd0);
    chk("midrst_fields", 64'({d_if.opcode, d_if.rs, d_if.rt, d_if.rd, d_if.shamt, d_if.funct}), 64'd0);
    chk("midrst_outputs", {d_if.readData1, d_if.immediate}, 64'd0);
    chk("midrst_controls", 64'({d_if.memRead, d_if.memToReg, d_if.aluSrc, d_if.regWrite,
                                d_if.overrun}), 64'd0);
    xs(32'h8D2A0000);

    // randomized traffic
    do_reset();
    for (int t = 0; t < 150; t++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: op = 6'b000000;
        1: op = 6'b100011;
        2: op = 6'b101011;
        3: op = 6'b000100;
        4: op = 6'b001000;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b111111})
            op = 6'b000010;
        end
      endcase
      ins = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      for (int i = 0; i < 4; i++) begin
        wen[i] = 1'($urandom_range(0, 1));
        wa[i]  = 5'($urandom_range(0, 7));
        wd[i]  = $urandom;
      end
      xact(ins, wen, wa, wd, 1'b0);
    end

    // halt, then a token that must be ignored
    xs(32'hFC000000);
    chk("endProgram", 64'(d_if.endProgram), 64'd1);
    d_if.stage2 = 1'b1;
    d_if.curInstruction = 32'h8C430004;
    @(posedge clock); #1;
    idle_inputs();
    repeat (6) @(posedge clock);
    #1;
    chk("halt_overrun", 64'(d_if.overrun), 64'd0);
    chk("halt_endProgram", 64'(d_if.endProgram), 64'd1);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    #1;
    chk("drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
